// File: rtl/pe_pkg.sv
// Shared definitions for the systolic-array processing element.
// Provides the default operand/accumulator widths and the matching
// operand and accumulator types, reused by the array top level.
package pe_pkg;

  localparam int unsigned PE_DATA_W = 8;
  localparam int unsigned PE_ACC_W  = 16;

  typedef logic [PE_DATA_W-1:0] pe_operand_t;
  typedef logic [PE_ACC_W-1:0]  pe_acc_t;

endpackage

// File: rtl/pe_mac.sv
// Combinational multiply-accumulate for one PE:
//   c_o = f(c_i + a_i*b_i)
// The product is formed at 2*DATA_W bits and extended to ACC_W.
// The sum is formed at ACC_W+1 bits, then either wrapped or clamped.
// Ports:
//   a_i, b_i : DATA_W operands
//   c_i      : ACC_W incoming partial sum
//   c_o      : ACC_W next partial sum
module pe_mac
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W   = PE_DATA_W,
  parameter int unsigned ACC_W    = PE_ACC_W,
  parameter int unsigned SIGNED   = 0,
  parameter int unsigned SATURATE = 0
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [ACC_W-1:0]  c_i,
  output logic [ACC_W-1:0]  c_o
);

  logic signed [2*DATA_W-1:0] sa;
  logic signed [2*DATA_W-1:0] sb;
  logic        [2*DATA_W-1:0] prod;
  logic        [ACC_W-1:0]    prod_ext;
  logic        [ACC_W:0]      sum;

  always_comb begin
    sa       = '0;
    sb       = '0;
    prod     = '0;
    prod_ext = '0;
    sum      = '0;
    if (SIGNED != 0) begin
      sa       = {{DATA_W{a_i[DATA_W-1]}}, a_i};
      sb       = {{DATA_W{b_i[DATA_W-1]}}, b_i};
      prod     = sa * sb;
      prod_ext = ACC_W'($signed(prod));
      sum      = {c_i[ACC_W-1], c_i} + {prod_ext[ACC_W-1], prod_ext};
    end else begin
      prod     = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
      prod_ext = ACC_W'(prod);
      sum      = {1'b0, c_i} + {1'b0, prod_ext};
    end

    c_o = sum[ACC_W-1:0];
    if (SATURATE != 0) begin
      if (SIGNED != 0) begin
        // Signed overflow shows as the guard bit disagreeing with the MSB;
        // the guard bit carries the true sign of the result.
        if (sum[ACC_W] != sum[ACC_W-1]) begin
          c_o = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                           : {1'b0, {(ACC_W-1){1'b1}}};
        end
      end else if (sum[ACC_W]) begin
        c_o = '1;
      end
    end
  end

endmodule

// File: rtl/just_trying_out_new_things.sv
// Leaf processing element of the systolic matrix multiplier.
// Each enabled cycle registers cout = cin + ain*bin and forwards the
// operands: aout east, bout south. One-cycle latency on all paths.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset, overrides enable
//   enable : clock enable for all three registers
//   ain    : row operand from west      -> aout to east
//   bin    : column operand from north  -> bout to south
//   cin    : incoming partial sum       -> cout registered MAC result
module just_trying_out_new_things
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W   = PE_DATA_W,
  parameter int unsigned ACC_W    = PE_ACC_W,
  parameter int unsigned SIGNED   = 0,
  parameter int unsigned SATURATE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] ain,
  input  logic [DATA_W-1:0] bin,
  input  logic [ACC_W-1:0]  cin,
  output logic [DATA_W-1:0] aout,
  output logic [DATA_W-1:0] bout,
  output logic [ACC_W-1:0]  cout
);

  logic [DATA_W-1:0] aout_q;
  logic [DATA_W-1:0] bout_q;
  logic [ACC_W-1:0]  cout_q;
  logic [ACC_W-1:0]  cout_d;

  pe_mac #(
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W),
    .SIGNED  (SIGNED),
    .SATURATE(SATURATE)
  ) u_mac (
    .a_i(ain),
    .b_i(bin),
    .c_i(cin),
    .c_o(cout_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      aout_q <= '0;
      bout_q <= '0;
      cout_q <= '0;
    end else if (enable) begin
      aout_q <= ain;
      bout_q <= bin;
      cout_q <= cout_d;
    end
  end

  assign aout = aout_q;
  assign bout = bout_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_just_trying_out_new_things.sv
module tb_just_trying_out_new_things;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  ain;
  logic [7:0]  bin;
  logic [15:0] cin;

  // uu: unsigned wrap, us: unsigned sat, su: signed wrap, ss: signed sat
  logic [7:0]  aout_uu, bout_uu, aout_us, bout_us, aout_su, bout_su, aout_ss, bout_ss;
  logic [15:0] cout_uu, cout_us, cout_su, cout_ss;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  just_trying_out_new_things #(.DATA_W(8), .ACC_W(16), .SIGNED(0), .SATURATE(0)) u_uu (
    .clk(clk), .reset(reset), .enable(enable), .ain(ain), .bin(bin), .cin(cin),
    .aout(aout_uu), .bout(bout_uu), .cout(cout_uu));
  just_trying_out_new_things #(.DATA_W(8), .ACC_W(16), .SIGNED(0), .SATURATE(1)) u_us (
    .clk(clk), .reset(reset), .enable(enable), .ain(ain), .bin(bin), .cin(cin),
    .aout(aout_us), .bout(bout_us), .cout(cout_us));
  just_trying_out_new_things #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(0)) u_su (
    .clk(clk), .reset(reset), .enable(enable), .ain(ain), .bin(bin), .cin(cin),
    .aout(aout_su), .bout(bout_su), .cout(cout_su));
  just_trying_out_new_things #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(1)) u_ss (
    .clk(clk), .reset(reset), .enable(enable), .ain(ain), .bin(bin), .cin(cin),
    .aout(aout_ss), .bout(bout_ss), .cout(cout_ss));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // One clock edge; inputs are changed and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] c);
    reset  = r;
    enable = e;
    ain    = a;
    bin    = b;
    cin    = c;
  endtask

  // Expected pipeline and cout of all four variants.
  task automatic expect4(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                         input logic [15:0] c_uu, input logic [15:0] c_us,
                         input logic [15:0] c_su, input logic [15:0] c_ss);
    check({tag, " aout"},    32'(aout_uu), 32'(ea));
    check({tag, " bout"},    32'(bout_uu), 32'(eb));
    check({tag, " aout_ss"}, 32'(aout_ss), 32'(ea));
    check({tag, " bout_su"}, 32'(bout_su), 32'(eb));
    check({tag, " aout_us"}, 32'(aout_us), 32'(ea));
    check({tag, " bout_us"}, 32'(bout_us), 32'(eb));
    check({tag, " aout_su"}, 32'(aout_su), 32'(ea));
    check({tag, " bout_ss"}, 32'(bout_ss), 32'(eb));
    check({tag, " cout_uu"}, 32'(cout_uu), 32'(c_uu));
    check({tag, " cout_us"}, 32'(cout_us), 32'(c_us));
    check({tag, " cout_su"}, 32'(cout_su), 32'(c_su));
    check({tag, " cout_ss"}, 32'(cout_ss), 32'(c_ss));
  endtask

  initial begin
    drive(1'b1, 1'b1, 8'd5, 8'd6, 16'd7);
    #1;
    step();
    expect4("reset_en", 8'd0, 8'd0, 16'd0, 16'd0, 16'd0, 16'd0);

    // Load non-zero state, then reset with enable low must still clear.
    drive(1'b0, 1'b1, 8'd5, 8'd6, 16'd7);
    step();
    expect4("preload", 8'd5, 8'd6, 16'd37, 16'd37, 16'd37, 16'd37);
    drive(1'b1, 1'b0, 8'd11, 8'd12, 16'd13);
    step();
    expect4("reset_noen", 8'd0, 8'd0, 16'd0, 16'd0, 16'd0, 16'd0);

    drive(1'b0, 1'b1, 8'd1, 8'd1, 16'd1);
    step();
    expect4("mac_1", 8'd1, 8'd1, 16'd2, 16'd2, 16'd2, 16'd2);
    drive(1'b0, 1'b1, 8'd2, 8'd2, 16'd2);
    step();
    expect4("mac_2", 8'd2, 8'd2, 16'd6, 16'd6, 16'd6, 16'd6);
    drive(1'b0, 1'b1, 8'd0, 8'd3, 16'd1);
    step();
    expect4("zero_a", 8'd0, 8'd3, 16'd1, 16'd1, 16'd1, 16'd1);

    drive(1'b0, 1'b0, 8'd9, 8'd9, 16'd9);
    for (int i = 0; i < 3; i++) begin
      step();
      expect4("hold", 8'd0, 8'd3, 16'd1, 16'd1, 16'd1, 16'd1);
    end

    // 255*255+1000 = 66025: wraps to 489 unsigned; signed is (-1)(-1)+1000.
    drive(1'b0, 1'b1, 8'd255, 8'd255, 16'd1000);
    step();
    expect4("ovf_u", 8'd255, 8'd255, 16'd489, 16'd65535, 16'd1001, 16'd1001);

    // Unsigned 254*3+10 = 772; signed -2*3+10 = 4.
    drive(1'b0, 1'b1, 8'hFE, 8'd3, 16'd10);
    step();
    expect4("neg_a", 8'hFE, 8'd3, 16'd772, 16'd772, 16'd4, 16'd4);

    // 128*128 and (-128)(-128) both 16384.
    drive(1'b0, 1'b1, 8'h80, 8'h80, 16'd0);
    step();
    expect4("min_sq", 8'h80, 8'h80, 16'd16384, 16'd16384, 16'd16384, 16'd16384);

    // 127*127 + 32767 = 48896 = 0xBF00: positive signed overflow.
    drive(1'b0, 1'b1, 8'h7F, 8'h7F, 16'h7FFF);
    step();
    expect4("ovf_pos", 8'h7F, 8'h7F, 16'hBF00, 16'hBF00, 16'hBF00, 16'h7FFF);

    // Signed: -16256 + -32768 = -49024 -> wraps to 0x4080, clamps to 0x8000.
    // Unsigned: 16256 + 32768 = 49024 = 0xBF80.
    drive(1'b0, 1'b1, 8'h80, 8'h7F, 16'h8000);
    step();
    expect4("ovf_neg", 8'h80, 8'h7F, 16'hBF80, 16'hBF80, 16'h4080, 16'h8000);

    // Mid-stream reset then resume.
    drive(1'b1, 1'b1, 8'd50, 8'd60, 16'd70);
    step();
    expect4("reset_mid", 8'd0, 8'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    drive(1'b0, 1'b1, 8'd3, 8'd4, 16'd5);
    step();
    expect4("resume", 8'd3, 8'd4, 16'd17, 16'd17, 16'd17, 16'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/just_trying_out_new_things.md
Name: just_trying_out_new_things

Overview:
Single processing element (PE) of the pipelined systolic matrix multiplier. Each enabled cycle it registers a multiply-accumulate, cout = cin + ain*bin. It also forwards ain and bin, registered, to the neighbouring PEs: aout goes east and bout goes south. PEs tile into an N x N array; this block is the leaf cell.

Parameters:
DATA_W, 8, width of ain/bin/aout/bout operands.
ACC_W, 16, width of cin/cout partial sums; must be >= 2*DATA_W.
SIGNED, 0, 0 = unsigned operands and sum; 1 = two's-complement operands and sum.
SATURATE, 0, 0 = sum wraps modulo 2^ACC_W; 1 = sum clamps to the ACC_W range.

Ports:
clk  input  1  clock, all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  clock enable for all registers.
ain  input  DATA_W  row operand from west neighbour.
bin  input  DATA_W  column operand from north neighbour.
cin  input  ACC_W  incoming partial sum.
aout  output  DATA_W  registered ain, to east neighbour.
bout  output  DATA_W  registered bin, to south neighbour.
cout  output  ACC_W  registered partial sum cin + ain*bin.

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset), sampled only on the rising edge of clk.
- Priority at each rising edge: reset, then enable, then hold.
- reset=1: aout, bout and cout all become 0 at that edge, regardless of enable or the data inputs.
- reset=0, enable=1: aout<=ain, bout<=bin, cout<=f(cin + ain*bin).
- reset=0, enable=0: all three outputs hold their previous values; the inputs are ignored.
- Latency: 1 cycle from input sample to output, for all three paths. No handshake; data is valid every enabled cycle.
- Arithmetic:
  - The product is computed at full 2*DATA_W width, then extended to ACC_W: zero-extended when SIGNED=0, sign-extended when SIGNED=1.
  - The sum is computed at ACC_W+1 bits.
  - SATURATE=0: cout takes the low ACC_W bits (wrap).
  - SATURATE=1, unsigned: clamp to 2^ACC_W-1.
  - SATURATE=1, signed: clamp to the max/min two's-complement value on overflow.
- aout and bout are pure pipeline copies; they are never modified by the arithmetic settings.
- Reset asserted mid-stream clears in-flight data; the next enabled edge after reset deasserts resumes normally.
- Outputs are X-free after the first reset edge; before the first reset they are undefined.

Decomposition:
- Shared package pe_pkg: default DATA_W/ACC_W constants and a typedef for the operand type and the accumulator type, reused by the array top level.
- One combinational sub-module, pe_mac: multiply, extend, add, saturate. It takes ain, bin, cin and produces the next cout value.
- The PE itself holds only the three registers plus the reset/enable logic.

Test Plan:
1. reset=1 for one edge with non-zero inputs -> aout=0, bout=0, cout=0 after that edge; with reset=1 and enable=0 the outputs still clear.
2. enable=1, ain=1, bin=1, cin=1 -> next edge aout=1, bout=1, cout=2. Then ain=2, bin=2, cin=2 -> aout=2, bout=2, cout=6.
3. ain=0, bin=3, cin=1 -> aout=0, bout=3, cout=1 (zero-operand product).
4. enable=0, ain=9, bin=9, cin=9 -> aout, bout and cout hold the prior values (0/3/1) for all subsequent edges until enable returns high.
5. Overflow, default parameters: ain=255, bin=255, cin=1000 -> cout=489 (wrap). With SATURATE=1 -> cout=65535.
6. SIGNED=1: ain=-2 (8'hFE), bin=3, cin=10 -> cout=4. Then ain=-128, bin=-128, cin=0 -> cout=16384.
